// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: FSM state encoding and operand width shared by mult_arbiter and its sub-blocks
package mult_arb_pkg;
  localparam int OP_W = 8;
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, DONE = 2'b11} state_t;
endpackage

// File: rtl/arbitro_rr2.sv
// arbitro_rr2: two-way round-robin arbiter producing a one-hot grant
//   req0/req1 : requests
//   last      : last served requester (1 = requester 1), favoured against on a tie
//   en        : grant enable; no grant is issued while low
//   gnt       : one-hot grant {gnt1, gnt0}
module arbitro_rr2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);
  always_comb gnt = !en ? 2'b00 : (req0 && req1) ? (last ? 2'b01 : 2'b10) : {req1, req0};
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one external 8x8 saturating multiplier between two requesters
//   clock, reset (sync, active-low)
//   req0/req1, a0/b0/a1/b1  : requests and operands
//   gnt0/gnt1, done0/done1  : grant (LOAD..DONE) and one-cycle completion pulse
//   result, ovf             : captured product and overflow of the last completed operation
//   mul_a/mul_b/mul_start/mul_reset, mul_resultado/mul_overflow/mul_pronto : multiplier link
//   MULT_ARBITER_SWAP_EN    : when defined, the smaller operand goes to mul_b to shorten the run
module mult_arbiter
  import mult_arb_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            req0,
  input  logic            req1,
  input  logic [OP_W-1:0] a0,
  input  logic [OP_W-1:0] b0,
  input  logic [OP_W-1:0] a1,
  input  logic [OP_W-1:0] b1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            done0,
  output logic            done1,
  output logic [OP_W-1:0] result,
  output logic            ovf,
  output logic [OP_W-1:0] mul_a,
  output logic [OP_W-1:0] mul_b,
  output logic            mul_start,
  output logic            mul_reset,
  input  logic [OP_W-1:0] mul_resultado,
  input  logic            mul_overflow,
  input  logic            mul_pronto
);
  state_t state, state_nx;
  logic [1:0] gnt;
  logic sel;
  logic [OP_W-1:0] a_sel, b_sel, a_ld, b_ld;
  arbitro_rr2 u_rr (.req0(req0), .req1(req1), .last(sel), .en(state == IDLE), .gnt(gnt));
  assign a_sel = gnt[1] ? a1 : a0;
  assign b_sel = gnt[1] ? b1 : b0;
`ifdef MULT_ARBITER_SWAP_EN
  // run length follows mul_b, so feed it the smaller operand
  assign a_ld = (a_sel < b_sel) ? b_sel : a_sel;
  assign b_ld = (a_sel < b_sel) ? a_sel : b_sel;
`else
  assign a_ld = a_sel;
  assign b_ld = b_sel;
`endif
  always_ff @(posedge clock) state <= !reset ? IDLE : state_nx;
  always_comb begin
    state_nx  = state;
    if (state == IDLE && |gnt) state_nx = LOAD;
    if (state == LOAD) state_nx = RUN;
    if (state == RUN && mul_pronto) state_nx = DONE;
    if (state == DONE) state_nx = IDLE;
    gnt0      = state != IDLE && !sel;
    gnt1      = state != IDLE && sel;
    done0     = state == DONE && !sel;
    done1     = state == DONE && sel;
    mul_start = state == LOAD;
  end
  // sel doubles as the round-robin pointer: reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clock) begin
    mul_reset <= !reset;
    if (!reset) begin
      sel    <= 1'b1;
      mul_a  <= '0;
      mul_b  <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      if (|gnt) begin
        sel   <= gnt[1];
        mul_a <= a_ld;
        mul_b <= b_ld;
      end
      if (state == RUN && mul_pronto) begin
        result <= mul_resultado;
        ovf    <= mul_overflow;
      end
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: table-driven, hand-sequenced and random checks of mult_arbiter against a timeline model
module tb_mult_arbiter;
`ifdef MULT_ARBITER_SWAP_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif
  logic clock = 0, reset = 0, req0 = 0, req1 = 0;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic gnt0, gnt1, done0, done1, ovf, mul_start, mul_reset, mul_overflow, mul_pronto;
  logic [7:0] result, mul_a, mul_b, mul_resultado;
  logic [7:0] cnt = 0;
  logic [15:0] p16;
  int errors = 0, checks = 0, ecnt = 0;
  always #5 clock = ~clock;
  mult_arbiter dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .ovf(ovf), .mul_a(mul_a), .mul_b(mul_b),
    .mul_start(mul_start), .mul_reset(mul_reset),
    .mul_resultado(mul_resultado), .mul_overflow(mul_overflow), .mul_pronto(mul_pronto)
  );
  // external multiplier: counts from 0 after start, done when the count equals mul_b
  assign p16           = 16'(mul_a) * 16'(mul_b);
  assign mul_resultado = p16 > 16'd255 ? 8'hff : p16[7:0];
  assign mul_overflow  = p16 > 16'd255;
  assign mul_pronto    = cnt == mul_b;
  always @(posedge clock) cnt <= (mul_reset || mul_start) ? 8'd0 : (cnt != mul_b ? cnt + 8'd1 : cnt);
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", nm, got, exp, ecnt);
    end
  endtask
  // timeline model: an accept at edge k puts LOAD after k and DONE after k+2+B; next accept at k+4+B
  int op_k = -100, op_b = 0, free_edge = 0, op_res = 0, op_ovf = 0;
  int exp_res = 0, exp_ovf = 0, exp_a = 0, exp_b = 0, x, y, s;
  bit op_w = 0, ptr = 1, op_on = 0, fly;
  initial forever begin
    @(posedge clock);
    ecnt++;
    #1;
    if (!reset) begin
      op_on = 0; ptr = 1; free_edge = ecnt + 1;
      exp_res = 0; exp_ovf = 0; exp_a = 0; exp_b = 0;
    end else begin
      if (op_on && ecnt == op_k + 2 + op_b) begin
        exp_res = op_res; exp_ovf = op_ovf;
      end
      if (ecnt >= free_edge && (req0 || req1)) begin
        op_w = (req0 && req1) ? !ptr : req1;
        ptr = op_w;
        x = op_w ? int'(a1) : int'(a0);
        y = op_w ? int'(b1) : int'(b0);
        if (SW && y > x) begin s = x; x = y; y = s; end
        op_res = x * y > 255 ? 255 : x * y;
        op_ovf = x * y > 255 ? 1 : 0;
        op_on = 1; op_k = ecnt; op_b = y; free_edge = ecnt + 4 + y;
        exp_a = x; exp_b = y;
      end
    end
    fly = op_on && ecnt >= op_k && ecnt <= op_k + 2 + op_b;
    chk("gnt0", gnt0, fly && !op_w);
    chk("gnt1", gnt1, fly && op_w);
    chk("done0", done0, op_on && ecnt == op_k + 2 + op_b && !op_w);
    chk("done1", done1, op_on && ecnt == op_k + 2 + op_b && op_w);
    chk("mul_start", mul_start, op_on && ecnt == op_k);
    chk("mul_reset", mul_reset, !reset);
    chk("result", result, exp_res);
    chk("ovf", ovf, exp_ovf);
    if (fly || !reset) begin
      chk("mul_a", mul_a, exp_a);
      chk("mul_b", mul_b, exp_b);
    end
  end
  task automatic wait_done(output int d, output bit w, input int lim);
    d = -1; w = 0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clock); #1;
      if (done0 || done1) begin d = ecnt; w = done1; return; end
    end
    checks++; errors++;
    $display("FAIL done_timeout: no done pulse within %0d cycles at edge %0d", lim, ecnt);
  endtask
  typedef struct {
    bit r0, r1;
    int a0, b0, a1, b1;
    bit who;
    int res, ovf, lat, lat_sw;
  } vec_t;
  vec_t tbl [8];
  initial begin
    int t, d, nd;
    bit w;
    tbl[0] = '{1, 0, 12, 10, 0, 0, 0, 120, 0, 13, 13};
    tbl[1] = '{0, 1, 0, 0, 20, 20, 1, 255, 1, 23, 23};
    tbl[2] = '{1, 0, 77, 0, 0, 0, 0, 0, 0, 3, 3};
    tbl[3] = '{1, 1, 5, 6, 7, 3, 1, 21, 0, 6, 6};
    tbl[4] = '{1, 1, 16, 16, 1, 1, 0, 255, 1, 19, 19};
    tbl[5] = '{1, 0, 2, 200, 0, 0, 0, 255, 1, 203, 5};
    tbl[6] = '{0, 1, 0, 0, 255, 1, 1, 255, 0, 4, 4};
    tbl[7] = '{0, 1, 0, 0, 15, 17, 1, 255, 0, 20, 18};
    repeat (3) @(negedge clock);
    reset = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      req0 = tbl[i].r0; req1 = tbl[i].r1;
      a0 = 8'(tbl[i].a0); b0 = 8'(tbl[i].b0); a1 = 8'(tbl[i].a1); b1 = 8'(tbl[i].b1);
      t = ecnt + 1;
      wait_done(d, w, 400);
      @(negedge clock);
      req0 = 0; req1 = 0;
      if (d >= 0) begin
        chk("tbl_who", w, tbl[i].who);
        chk("tbl_result", result, tbl[i].res);
        chk("tbl_ovf", ovf, tbl[i].ovf);
        chk("tbl_latency", d + 1 - t, SW ? tbl[i].lat_sw : tbl[i].lat);
      end
    end
    @(negedge clock);
    a0 = 9; b0 = 9; req0 = 1;
    for (int i = 0; i < 10 && !gnt0; i++) begin @(posedge clock); #1; end
    @(negedge clock);
    req0 = 0; a0 = 1; b0 = 1;
    wait_done(d, w, 100);
    chk("drop_who", w, 0);
    chk("drop_result", result, 81);
    @(negedge clock);
    a0 = 3; b0 = 50; req0 = 1;
    repeat (5) @(negedge clock);
    reset = 0; req0 = 0;
    @(posedge clock); #1;
    chk("abort_gnt0", gnt0, 0);
    chk("abort_result", result, 0);
    chk("abort_mul_reset", mul_reset, 1);
    chk("abort_mul_a", mul_a, 0);
    @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
    chk("abort_mul_reset_end", mul_reset, 0);
    nd = 0;
    for (int i = 0; i < 60; i++) begin @(posedge clock); #1; if (done0 || done1) nd++; end
    chk("abort_no_done", nd, 0);
    @(negedge clock);
    a0 = 4; b0 = 3; a1 = 5; b1 = 2; req0 = 1; req1 = 1;
    for (int k = 0; k < 4; k++) begin
      wait_done(d, w, 50);
      chk("alt_who", w, k % 2);
      if (k < 3) begin
        for (int i = 0; i < 10; i++) begin @(posedge clock); #1; if (mul_start) break; end
        chk("alt_gap", ecnt - d, 2);
      end
    end
    @(negedge clock);
    req0 = 0; req1 = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clock);
      reset = $urandom_range(0, 79) != 0;
      req0 = $urandom_range(0, 2) == 0;
      req1 = $urandom_range(0, 2) == 0;
      a0 = 8'($urandom); a1 = 8'($urandom);
      b0 = 8'($urandom_range(0, 12)); b1 = 8'($urandom_range(0, 12));
    end
    @(negedge clock);
    reset = 1; req0 = 0; req1 = 0;
    repeat (30) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-002 RESET  input  1  synchronous, active-low reset; sampled on the rising edge of CLOCK.
REQ-003 REQ0, REQ1  input  1 each  level request from requester 0 and requester 1.
REQ-004 A0, B0, A1, B1  input  8 each  operands of each requester.
REQ-005 GNT0, GNT1  output  1 each  high from LOAD through DONE for the granted requester.
REQ-006 DONE0, DONE1  output  1 each  one-cycle completion pulse for the granted requester.
REQ-007 RESULT  output  8  registered saturated product of the last completed operation.
REQ-008 OVF  output  1  registered overflow flag of the last completed operation.
REQ-009 MUL_A, MUL_B  output  8 each  operands driven to the shared multiplicador8x8.
REQ-010 MUL_START  output  1  start pulse to the multiplier.
REQ-011 MUL_RESET  output  1  active-high multiplier reset.
REQ-012 MUL_RESULTADO  input  8  multiplier result.
REQ-013 MUL_OVERFLOW  input  1  multiplier overflow flag.
REQ-014 MUL_PRONTO  input  1  multiplier done flag; high when its internal count equals MUL_B.

Function
REQ-015 The FSM SHALL have four states, IDLE, LOAD, RUN and DONE, with transitions IDLE->LOAD on any request, LOAD->RUN unconditionally, RUN->DONE when MUL_PRONTO=1, and DONE->IDLE unconditionally.
REQ-016 In IDLE, if exactly one REQx=1 the block SHALL grant requester x; if both are high it SHALL grant the requester not served last (round-robin).
REQ-017 On the IDLE->LOAD edge the block SHALL latch the granted operands into internal registers, and MUL_A/MUL_B SHALL be driven from those registers, stable from LOAD until DONE.
REQ-018 MUL_START SHALL be 1 only during LOAD.
REQ-019 MUL_PRONTO SHALL be sampled only in RUN; in IDLE, LOAD and DONE it SHALL be ignored.
REQ-020 On the RUN->DONE edge, RESULT and OVF SHALL capture MUL_RESULTADO and MUL_OVERFLOW, and SHALL hold those values until the next capture.
REQ-021 DONEx SHALL be high only in the DONE cycle of granted requester x.
REQ-022 Latency: if REQ is sampled at edge t, LOAD SHALL be cycle t+1, RUN SHALL span cycles t+2 to t+2+MUL_B, and DONE SHALL be cycle t+3+MUL_B.
REQ-023 When MUL_B=0, RUN SHALL last exactly one cycle and RESULT SHALL be 0.
REQ-024 Deassertion of REQx after grant SHALL NOT abort the operation; the DONE pulse SHALL still occur.
REQ-025 REQx still high in the IDLE cycle after DONE SHALL be treated as a new request, subject to round-robin.
REQ-026 Operand changes on A/B inputs after grant SHALL NOT affect the running operation.

Reset
REQ-027 While RESET=0 at an edge, the block SHALL enter IDLE; GNTx, DONEx, MUL_START, RESULT and OVF SHALL be 0; MUL_A/MUL_B SHALL be 0; the round-robin pointer SHALL favour requester 0.
REQ-028 MUL_RESET SHALL be 1 in the cycle following any edge at which RESET=0, and 0 otherwise.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no DONE pulse, and RESULT/OVF SHALL be cleared.

Configuration
REQ-030 The macro MULT_ARBITER_SWAP_EN SHALL control operand ordering: when defined, the block SHALL latch the smaller operand into MUL_B and the larger into MUL_A (latency t+3+min(A,B)), with identical RESULT/OVF; when undefined, the block SHALL pass operands unswapped (MUL_A=Ax, MUL_B=Bx).

Structure
REQ-031 The package mult_arb_pkg SHALL hold the state encoding (2-bit, with IDLE=00, LOAD=01, RUN=10 and DONE=11) and the operand-width constant (8).
REQ-032 The round-robin grant logic SHALL be the sub-module arbitro_rr2, which takes two requests, the last-served pointer and an update enable, and produces a one-hot grant.

Verification
REQ-033 Scenario 1: REQ0 with A0=12, B0=10 -> GNT0 high; DONE0 pulse in cycle t+13; RESULT=120; OVF=0.
REQ-034 Scenario 2: REQ1 with A1=20, B1=20 -> RESULT=255 and OVF=1.
REQ-035 Scenario 3: REQ0 and REQ1 held high continuously after reset -> grants alternate 0,1,0,1, and each DONE is followed by LOAD of the other requester two cycles later.
REQ-036 Scenario 4: B0=0, A0=77 -> RUN lasts 1 cycle; RESULT=0; DONE0 in cycle t+3.
REQ-037 Scenario 5: RESET=0 in cycle t+5 of an A=3, B=50 operation -> no DONE pulse; all outputs 0; MUL_RESET=1 for one cycle.
REQ-038 Scenario 6: with MULT_ARBITER_SWAP_EN defined, A0=2, B0=200 -> MUL_B=2; DONE0 in cycle t+5; RESULT=255; OVF=1.
